// File: rtl/sddr_pkg.sv
// Shared encodings for the DDR3 init/refresh sequencer: command pins, FSM states, A10 index.
package sddr_pkg;

  localparam int unsigned TIMER_W = 32;
  localparam int unsigned A10_BIT = 10;

  // {ras_n, cas_n, we_n} with cs_n low
  typedef enum logic [2:0] {
    CMD_MRS  = 3'b000,
    CMD_REF  = 3'b001,
    CMD_PRE  = 3'b010,
    CMD_ZQCL = 3'b110,
    CMD_NOP  = 3'b111
  } cmd_e;

  localparam logic [3:0] ST_BOOT     = 4'd0;
  localparam logic [3:0] ST_RST_HOLD = 4'd1;
  localparam logic [3:0] ST_CKE_WAIT = 4'd2;
  localparam logic [3:0] ST_XPR      = 4'd3;
  localparam logic [3:0] ST_MR2      = 4'd4;
  localparam logic [3:0] ST_MR3      = 4'd5;
  localparam logic [3:0] ST_MR1      = 4'd6;
  localparam logic [3:0] ST_MR0      = 4'd7;
  localparam logic [3:0] ST_ZQCL     = 4'd8;
  localparam logic [3:0] ST_IDLE     = 4'd9;
  localparam logic [3:0] ST_REQ      = 4'd10;
  localparam logic [3:0] ST_PREA     = 4'd11;
  localparam logic [3:0] ST_REF      = 4'd12;

endpackage

// File: rtl/sddr_wait_timer.sv
// Loadable down-counter; done pulses for one cycle when the count reaches zero.
module sddr_wait_timer
  import sddr_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               done
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        count <= load_val;
      end else if (count != '0) begin
        count <= count - TIMER_W'(1);
        done  <= (count == TIMER_W'(1));
      end
    end
  end

endmodule

// File: rtl/sddr_init_seq.sv
// DDR3 power-up sequencer and periodic PREA+REF scheduler driving the PHY ctl_* pins.
// SDDR_INIT_FAST_SIM_EN shortens the reset, CKE and ZQ-init waits to 16 cycles.
module sddr_init_seq
  import sddr_pkg::*;
#(
  parameter int unsigned BANK_BITS    = 3,
  parameter int unsigned ROW_BITS     = 13,
  parameter int unsigned T_RESET_CYC  = 66667,
  parameter int unsigned T_CKE_CYC    = 166667,
  parameter int unsigned T_XPR_CYC    = 90,
  parameter int unsigned T_MRD_CYC    = 4,
  parameter int unsigned T_MOD_CYC    = 12,
  parameter int unsigned T_ZQINIT_CYC = 512,
  parameter int unsigned T_RP_CYC     = 5,
  parameter int unsigned T_RFC_CYC    = 107,
  parameter int unsigned T_REFI_CYC   = 2600,
  parameter logic [ROW_BITS-1:0] MR0_VAL = '0,
  parameter logic [ROW_BITS-1:0] MR1_VAL = '0,
  parameter logic [ROW_BITS-1:0] MR2_VAL = '0,
  parameter logic [ROW_BITS-1:0] MR3_VAL = '0
) (
  input  logic                 in_ddr_clock_i,
  input  logic                 in_ctl_reset_n_i,
  output logic                 ddr_reset_n_o,
  output logic                 phy_reset_n_o,
  output logic                 ctl_cke_o,
  output logic                 ctl_cs_n_o,
  output logic                 ctl_ras_n_o,
  output logic                 ctl_cas_n_o,
  output logic                 ctl_we_n_o,
  output logic                 ctl_odt_o,
  output logic [BANK_BITS-1:0] ctl_ba_o,
  output logic [ROW_BITS-1:0]  ctl_addr_o,
  output logic                 ready_o,
  output logic                 refresh_req_o,
  input  logic                 refresh_gnt_i,
  output logic                 refresh_busy_o,
  output logic                 refresh_late_o
);

`ifdef SDDR_INIT_FAST_SIM_EN
  localparam int unsigned RESET_CYC  = 16;
  localparam int unsigned CKE_CYC    = 16;
  localparam int unsigned ZQINIT_CYC = 16;
`else
  localparam int unsigned RESET_CYC  = T_RESET_CYC;
  localparam int unsigned CKE_CYC    = T_CKE_CYC;
  localparam int unsigned ZQINIT_CYC = T_ZQINIT_CYC;
`endif

  // Timer reloads are N-1 so the next command lands exactly N cycles later
  localparam logic [TIMER_W-1:0] W_RESET = TIMER_W'(RESET_CYC - 1);
  localparam logic [TIMER_W-1:0] W_CKE   = TIMER_W'(CKE_CYC - 1);
  localparam logic [TIMER_W-1:0] W_XPR   = TIMER_W'(T_XPR_CYC - 1);
  localparam logic [TIMER_W-1:0] W_MRD   = TIMER_W'(T_MRD_CYC - 1);
  localparam logic [TIMER_W-1:0] W_MOD   = TIMER_W'(T_MOD_CYC - 1);
  localparam logic [TIMER_W-1:0] W_ZQ    = TIMER_W'(ZQINIT_CYC - 1);
  localparam logic [TIMER_W-1:0] W_RP    = TIMER_W'(T_RP_CYC - 1);
  localparam logic [TIMER_W-1:0] W_RFC   = TIMER_W'(T_RFC_CYC - 1);
  localparam logic [TIMER_W-1:0] W_REFI  = TIMER_W'(T_REFI_CYC - 1);
  localparam logic [ROW_BITS-1:0] A10_MASK = ROW_BITS'(1) << A10_BIT;

  logic [3:0]           state, nxt_state;
  logic                 ddr_rst_n, nxt_ddr_rst_n, phy_rst_n, nxt_phy_rst_n;
  logic                 cke, nxt_cke, cs_n, nxt_cs_n;
  logic [2:0]           cmd, nxt_cmd;
  logic [BANK_BITS-1:0] ba, nxt_ba;
  logic [ROW_BITS-1:0]  addr, nxt_addr;
  logic                 ready, nxt_ready, req, nxt_req, busy, nxt_busy;
  logic                 late, nxt_late, pending, nxt_pending;
  logic                 wt_load_c, wt_done, ref_issue_c, ref_done;
  logic [TIMER_W-1:0]   wt_val_c;

  sddr_wait_timer u_wait_timer (
    .clk      (in_ddr_clock_i),
    .rst_n    (in_ctl_reset_n_i),
    .load     (wt_load_c),
    .load_val (wt_val_c),
    .done     (wt_done)
  );

  // Refresh interval: free-running reload on expiry, restarted on each REF
  sddr_wait_timer u_refi_timer (
    .clk      (in_ddr_clock_i),
    .rst_n    (in_ctl_reset_n_i),
    .load     (ref_issue_c | ref_done),
    .load_val (W_REFI),
    .done     (ref_done)
  );

  always_ff @(posedge in_ddr_clock_i or negedge in_ctl_reset_n_i) begin
    if (!in_ctl_reset_n_i) begin
      state     <= ST_BOOT;
      ddr_rst_n <= 1'b0;
      phy_rst_n <= 1'b0;
      cke       <= 1'b0;
      cs_n      <= 1'b1;
      cmd       <= CMD_NOP;
      ba        <= '0;
      addr      <= '0;
      ready     <= 1'b0;
      req       <= 1'b0;
      busy      <= 1'b0;
      late      <= 1'b0;
      pending   <= 1'b0;
    end else begin
      state     <= nxt_state;
      ddr_rst_n <= nxt_ddr_rst_n;
      phy_rst_n <= nxt_phy_rst_n;
      cke       <= nxt_cke;
      cs_n      <= nxt_cs_n;
      cmd       <= nxt_cmd;
      ba        <= nxt_ba;
      addr      <= nxt_addr;
      ready     <= nxt_ready;
      req       <= nxt_req;
      busy      <= nxt_busy;
      late      <= nxt_late;
      pending   <= nxt_pending;
    end
  end

  always_comb begin
    nxt_state     = state;
    nxt_ddr_rst_n = ddr_rst_n;
    nxt_phy_rst_n = phy_rst_n;
    nxt_cke       = cke;
    nxt_cmd       = CMD_NOP;
    nxt_ba        = '0;
    nxt_addr      = '0;
    nxt_ready     = ready;
    nxt_req       = req;
    nxt_busy      = busy;
    nxt_late      = late;
    nxt_pending   = pending;
    wt_load_c     = 1'b0;
    wt_val_c      = '0;
    ref_issue_c   = 1'b0;

    // An expiry outside IDLE/REQ is remembered until the scheduler can act on it
    if (ref_done && state != ST_IDLE && state != ST_REQ) nxt_pending = 1'b1;

    case (state)
      ST_BOOT: begin
        nxt_state     = ST_RST_HOLD;
        nxt_phy_rst_n = 1'b1;
        wt_load_c     = 1'b1;
        wt_val_c      = W_RESET;
      end
      ST_RST_HOLD: if (wt_done) begin
        nxt_state     = ST_CKE_WAIT;
        nxt_ddr_rst_n = 1'b1;
        wt_load_c     = 1'b1;
        wt_val_c      = W_CKE;
      end
      ST_CKE_WAIT: if (wt_done) begin
        nxt_state = ST_XPR;
        nxt_cke   = 1'b1;
        wt_load_c = 1'b1;
        wt_val_c  = W_XPR;
      end
      ST_XPR: if (wt_done) begin
        nxt_state = ST_MR2;
        nxt_cmd   = CMD_MRS;
        nxt_ba    = BANK_BITS'(2);
        nxt_addr  = MR2_VAL;
        wt_load_c = 1'b1;
        wt_val_c  = W_MRD;
      end
      ST_MR2: if (wt_done) begin
        nxt_state = ST_MR3;
        nxt_cmd   = CMD_MRS;
        nxt_ba    = BANK_BITS'(3);
        nxt_addr  = MR3_VAL;
        wt_load_c = 1'b1;
        wt_val_c  = W_MRD;
      end
      ST_MR3: if (wt_done) begin
        nxt_state = ST_MR1;
        nxt_cmd   = CMD_MRS;
        nxt_ba    = BANK_BITS'(1);
        nxt_addr  = MR1_VAL;
        wt_load_c = 1'b1;
        wt_val_c  = W_MRD;
      end
      ST_MR1: if (wt_done) begin
        nxt_state = ST_MR0;
        nxt_cmd   = CMD_MRS;
        nxt_addr  = MR0_VAL;
        wt_load_c = 1'b1;
        wt_val_c  = W_MOD;
      end
      ST_MR0: if (wt_done) begin
        nxt_state = ST_ZQCL;
        nxt_cmd   = CMD_ZQCL;
        nxt_addr  = A10_MASK;
        wt_load_c = 1'b1;
        wt_val_c  = W_ZQ;
      end
      ST_ZQCL: if (wt_done) begin
        nxt_state   = ST_IDLE;
        nxt_ready   = 1'b1;
        ref_issue_c = 1'b1;
      end
      ST_IDLE: if (ref_done || pending) begin
        nxt_state   = ST_REQ;
        nxt_req     = 1'b1;
        nxt_pending = 1'b0;
      end
      ST_REQ: begin
        if (ref_done) nxt_late = 1'b1;
        if (refresh_gnt_i) begin
          nxt_state = ST_PREA;
          nxt_req   = 1'b0;
          nxt_busy  = 1'b1;
          nxt_cmd   = CMD_PRE;
          nxt_addr  = A10_MASK;
          wt_load_c = 1'b1;
          wt_val_c  = W_RP;
        end
      end
      ST_PREA: if (wt_done) begin
        nxt_state   = ST_REF;
        nxt_cmd     = CMD_REF;
        nxt_pending = 1'b0;
        ref_issue_c = 1'b1;
        wt_load_c   = 1'b1;
        wt_val_c    = W_RFC;
      end
      ST_REF: if (wt_done) begin
        nxt_state = ST_IDLE;
        nxt_busy  = 1'b0;
      end
      default: nxt_state = ST_BOOT;
    endcase

    // Deselect until CKE is high, then NOP with chip select asserted
    nxt_cs_n = ~nxt_cke;
  end

  assign ddr_reset_n_o  = ddr_rst_n;
  assign phy_reset_n_o  = phy_rst_n;
  assign ctl_cke_o      = cke;
  assign ctl_cs_n_o     = cs_n;
  assign ctl_ras_n_o    = cmd[2];
  assign ctl_cas_n_o    = cmd[1];
  assign ctl_we_n_o     = cmd[0];
  assign ctl_odt_o      = 1'b0;
  assign ctl_ba_o       = ba;
  assign ctl_addr_o     = addr;
  assign ready_o        = ready;
  assign refresh_req_o  = req;
  assign refresh_busy_o = busy;
  assign refresh_late_o = late;

endmodule

// File: tb/tb_sddr_init_seq.sv
// Scoreboard bench for sddr_init_seq: expected pin events are queued per phase and
// matched by a negedge monitor against observed commands and control-line edges.
module tb_sddr_init_seq;

  localparam int K_PHY = 1, K_DDR = 2, K_CKE = 3, K_CMD = 4, K_RDY = 5;
  localparam int K_REQR = 6, K_REQF = 7, K_BUSYR = 8, K_BUSYF = 9, K_LATE = 10, K_BAD = 11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gnt = 1'b0;
  logic        ddr_reset_n, phy_reset_n, cke, cs_n, ras_n, cas_n, we_n, odt;
  logic [2:0]  ba;
  logic [12:0] addr;
  logic        ready, req, busy, late;

  always #5 clk = ~clk;

  sddr_init_seq #(
    .BANK_BITS(3), .ROW_BITS(13),
    .T_RESET_CYC(16), .T_CKE_CYC(16), .T_XPR_CYC(90), .T_MRD_CYC(4), .T_MOD_CYC(12),
    .T_ZQINIT_CYC(16), .T_RP_CYC(5), .T_RFC_CYC(107), .T_REFI_CYC(100),
    .MR0_VAL(13'h0520), .MR1_VAL(13'h0044), .MR2_VAL(13'h0008), .MR3_VAL(13'h0004)
  ) dut (
    .in_ddr_clock_i(clk), .in_ctl_reset_n_i(rst_n),
    .ddr_reset_n_o(ddr_reset_n), .phy_reset_n_o(phy_reset_n),
    .ctl_cke_o(cke), .ctl_cs_n_o(cs_n), .ctl_ras_n_o(ras_n), .ctl_cas_n_o(cas_n),
    .ctl_we_n_o(we_n), .ctl_odt_o(odt), .ctl_ba_o(ba), .ctl_addr_o(addr),
    .ready_o(ready), .refresh_req_o(req), .refresh_gnt_i(gnt),
    .refresh_busy_o(busy), .refresh_late_o(late)
  );

  typedef struct {
    int          kind;
    int          cyc;
    logic [2:0]  cmd;
    logic [2:0]  ba;
    logic [12:0] addr;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic push(input int k, input int c, input logic [2:0] cm = 3'b111,
                      input logic [2:0] b = 3'd0, input logic [12:0] a = 13'd0);
    ev_t e;
    e.kind = k; e.cyc = c; e.cmd = cm; e.ba = b; e.addr = a;
    exp_q.push_back(e);
  endtask

  task automatic push_init(input bit full);
    push(K_PHY, 1);
    push(K_DDR, 17);
    push(K_CKE, 33);
    push(K_CMD, 123, 3'b000, 3'd2, 13'h0008);
    push(K_CMD, 127, 3'b000, 3'd3, 13'h0004);
    push(K_CMD, 131, 3'b000, 3'd1, 13'h0044);
    if (full) begin
      push(K_CMD, 135, 3'b000, 3'd0, 13'h0520);
      push(K_CMD, 147, 3'b110, 3'd0, 13'h0400);
      push(K_RDY, 163);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".ddr_reset_n"}, 32'(ddr_reset_n), 0);
    chk({tag, ".phy_reset_n"}, 32'(phy_reset_n), 0);
    chk({tag, ".cke"},         32'(cke), 0);
    chk({tag, ".cmd_pins"},    32'({cs_n, ras_n, cas_n, we_n}), 32'hF);
    chk({tag, ".odt"},         32'(odt), 0);
    chk({tag, ".ba_addr"},     32'({ba, addr}), 0);
    chk({tag, ".rdy_req_busy_late"}, 32'({ready, req, busy, late}), 0);
  endtask

  task automatic observe(input int k, input logic [2:0] cm, input logic [2:0] b, input logic [12:0] a);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d cmd=%b ba=%0d addr=%h at cyc %0d, none expected",
               k, cm, b, a, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.cmd !== cm || e.ba !== b || e.addr !== a) begin
        errors++;
        $display("FAIL event: got kind=%0d cyc=%0d cmd=%b ba=%0d addr=%h expected kind=%0d cyc=%0d cmd=%b ba=%0d addr=%h",
                 k, cyc, cm, b, a, e.kind, e.cyc, e.cmd, e.ba, e.addr);
      end
    end
  endtask

  // Monitor: edge and command detection on the falling clock edge
  logic p_phy = 0, p_ddr = 0, p_cke = 0, p_rdy = 0, p_req = 0, p_busy = 0, p_late = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (phy_reset_n && !p_phy) observe(K_PHY, 3'b111, 3'd0, 13'd0);
      if (ddr_reset_n && !p_ddr) observe(K_DDR, 3'b111, 3'd0, 13'd0);
      if (cke && !p_cke)         observe(K_CKE, 3'b111, 3'd0, 13'd0);
      if (!cs_n && {ras_n, cas_n, we_n} != 3'b111) observe(K_CMD, {ras_n, cas_n, we_n}, ba, addr);
      if (ready && !p_rdy)       observe(K_RDY, 3'b111, 3'd0, 13'd0);
      if (req && !p_req)         observe(K_REQR, 3'b111, 3'd0, 13'd0);
      if (!req && p_req)         observe(K_REQF, 3'b111, 3'd0, 13'd0);
      if (busy && !p_busy)       observe(K_BUSYR, 3'b111, 3'd0, 13'd0);
      if (!busy && p_busy)       observe(K_BUSYF, 3'b111, 3'd0, 13'd0);
      if (late && !p_late)       observe(K_LATE, 3'b111, 3'd0, 13'd0);
      if ((!phy_reset_n && p_phy) || (!ddr_reset_n && p_ddr) || (!cke && p_cke) ||
          (!ready && p_rdy) || (!late && p_late) || odt)
        observe(K_BAD, 3'b111, 3'd0, 13'd0);
    end
    p_phy = phy_reset_n; p_ddr = ddr_reset_n; p_cke = cke; p_rdy = ready;
    p_req = req; p_busy = busy; p_late = late;
  end

  task automatic wait_cyc(input int n);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cyc == n) return;
    end
    errors++;
    checks++;
    $display("FAIL wait_timeout: cycle %0d not reached, at %0d", n, cyc);
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    gnt   = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk_reset("por");

    // Phase 1: grant held high from power-up; idle grant is ignored until a request
    push_init(1'b1);
    push(K_REQR, 263);
    push(K_CMD, 264, 3'b010, 3'd0, 13'h0400);
    push(K_REQF, 264);
    push(K_BUSYR, 264);
    push(K_CMD, 269, 3'b001, 3'd0, 13'h0000);
    push(K_BUSYF, 376);
    push(K_REQR, 377);
    push(K_LATE, 469);
    push(K_CMD, 621, 3'b010, 3'd0, 13'h0400);
    push(K_REQF, 621);
    push(K_BUSYR, 621);
    push(K_CMD, 626, 3'b001, 3'd0, 13'h0000);
    push(K_BUSYF, 733);
    push(K_REQR, 734);
    release_reset();

    wait_cyc(200);
    chk("idle_gnt.busy", 32'(busy), 0);
    chk("idle_gnt.req", 32'(req), 0);
    chk("idle_gnt.cmd", 32'({cs_n, ras_n, cas_n, we_n}), 32'h7);
    chk("idle_gnt.ready", 32'(ready), 1);

    wait_cyc(376);
    gnt = 1'b0;
    wait_cyc(620);
    chk("withheld.late", 32'(late), 1);
    gnt = 1'b1;
    wait_cyc(621);
    gnt = 1'b0;
    wait_cyc(740);
    #1;
    chk("after_grant.late_sticky", 32'(late), 1);
    chk("after_grant.req", 32'(req), 1);
    chk("phase1.queue_drained", 32'(exp_q.size()), 0);

    // Phase 2: reset pulse from refresh operation, then again during the MR1 wait
    #1 rst_n = 1'b0;
    #1 chk_reset("rst_refresh");
    repeat (2) @(negedge clk);
    push_init(1'b0);
    release_reset();
    wait_cyc(133);
    #2 rst_n = 1'b0;
    #1 chk_reset("rst_mr1");
    chk("phase2.queue_drained", 32'(exp_q.size()), 0);
    repeat (2) @(negedge clk);

    // Phase 3: restart from RST_HOLD with grant withheld
    push_init(1'b1);
    release_reset();
    wait_cyc(180);
    #1;
    chk("restart.ready", 32'(ready), 1);
    chk("restart.busy", 32'(busy), 0);
    chk("phase3.queue_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
